// File: rtl/velocity_cell_arbiter.sv
// velocity_cell_arbiter
//
// Sequences one pass over a single-port velocity cell RAM. Address 0 holds the
// particle count N; addresses 1..N hold {vz, vy, vx}. A pass fetches N, streams
// reads of 1..N to the motion-update datapath and interleaves write-back of
// updated velocities. When both want the port, the write wins.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle pulse that begins a pass (IDLE only)
//   busy, done               pass in progress / one-cycle end-of-pass pulse
//   particle_num             clamped particle count for this pass
//   err                      sticky illegal-write-address flag
//   vel_out*                 read data, its address and valid (1-cycle latency)
//   wb_valid/addr/data/ready write-back request channel
//   mem_*                    RAM port (mem_q valid the cycle after mem_rden)
module velocity_cell_arbiter #(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_num,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] vel_out,
    output logic [ADDR_WIDTH-1:0] vel_out_addr,
    output logic                  vel_out_valid,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchNum,
        StWaitNum,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Address 0 holds the count, so at most PARTICLE_NUM-1 particles fit.
    localparam logic [ADDR_WIDTH-1:0] MaxNum = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH-1:0] wc_q, wc_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic                  err_q, err_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic [ADDR_WIDTH-1:0] num_fetched;
    logic [ADDR_WIDTH-1:0] num_clamped;
    logic                  wb_fire;
    logic                  wb_legal;

    assign num_fetched = mem_q[ADDR_WIDTH-1:0];
    assign num_clamped = (num_fetched > MaxNum) ? MaxNum : num_fetched;

    // wb_ready decodes the state register only, so it never depends on wb_valid.
    assign wb_ready = (state_q == StRun) || (state_q == StDrain);
    assign wb_fire  = wb_valid && wb_ready;
    assign wb_legal = wb_fire && (wb_addr != '0) && (wb_addr <= num_q);

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign particle_num  = num_q;
    assign err           = err_q;
    assign vel_out       = mem_q;
    assign vel_out_valid = rd_valid_q;
    assign vel_out_addr  = rd_addr_q;

    always_comb begin
        state_d     = state_q;
        rp_d        = rp_q;
        wc_d        = wc_q;
        num_d       = num_q;
        err_d       = err_q;
        rd_valid_d  = 1'b0;
        rd_addr_d   = '0;
        mem_address = '0;
        mem_data    = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;

        // Accepted writes are only possible in RUN/DRAIN. Illegal ones complete
        // the handshake but never reach the RAM or the write counter.
        if (wb_legal) begin
            mem_wren    = 1'b1;
            mem_address = wb_addr;
            mem_data    = wb_data;
            wc_d        = wc_q + 1'b1;
        end else if (wb_fire) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d   = 1'b0;
                    rp_d    = '0;
                    wc_d    = '0;
                    state_d = StFetchNum;
                end
            end
            StFetchNum: begin
                mem_rden = 1'b1;
                state_d  = StWaitNum;
            end
            StWaitNum: begin
                num_d = num_clamped;
                if (num_clamped == '0) begin
                    state_d = StDone;
                end else begin
                    rp_d    = ADDR_WIDTH'(1);
                    state_d = StRun;
                end
            end
            StRun: begin
                // Any accepted write (legal or not) takes this cycle's slot.
                if (!wb_fire) begin
                    mem_rden    = 1'b1;
                    mem_address = rp_q;
                    rd_valid_d  = 1'b1;
                    rd_addr_d   = rp_q;
                    rp_d        = rp_q + 1'b1;
                    if (rp_q == num_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Counts this cycle's write, so DONE follows the final write directly.
                if (wc_d >= num_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rp_q       <= '0;
            wc_q       <= '0;
            num_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rp_q       <= rp_d;
            wc_q       <= wc_d;
            num_q      <= num_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

endmodule

// File: tb/tb_velocity_cell_arbiter.sv
// Randomized bench for velocity_cell_arbiter with a RAM model and a
// transaction-level reference: reads come back in address order 1..N carrying
// the latest committed contents, legal writes are 1..N, illegal ones set err.
module tb_velocity_cell_arbiter;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] particle_num;
    logic [DW-1:0] vel_out;
    logic [AW-1:0] vel_out_addr;
    logic          vel_out_valid;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          wb_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] mem_q = '0;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_img [256];
    logic          ram_load = 1'b0;

    // Reference state
    logic [DW-1:0] shadow [256];
    int            exp_n, beats, exp_next, wr_cnt, done_cnt, rel, cur_mode;
    bit            mon_on = 1'b0;
    bit            exp_err = 1'b0;
    logic          mon_acc, mon_legal;
    logic [7:0]    beat_idx;

    int tests_run = 0;
    int tests_failed = 0;

    velocity_cell_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PARTICLE_NUM (PN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .particle_num  (particle_num),
        .err           (err),
        .vel_out       (vel_out),
        .vel_out_addr  (vel_out_addr),
        .vel_out_valid (vel_out_valid),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_load) ram <= ram_img;
        else if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle monitor, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (mon_on && !rst) begin
            mon_acc   = wb_valid && wb_ready;
            mon_legal = mon_acc && (wb_addr != 0) && (int'(wb_addr) <= exp_n);
            check("rw_excl", mem_rden && mem_wren, 0);
            check("wren", mem_wren, mon_legal);
            if (mon_legal) begin
                check("waddr", mem_address, wb_addr);
                check("wdata", mem_data, wb_data);
            end
            if (!mem_rden && !mem_wren) begin
                check("idle_addr", mem_address, 0);
                check("idle_data", mem_data, 0);
            end
            check("err", err, exp_err);
            if (exp_n == 0) check("wb_ready_empty", wb_ready, 0);
            if (!busy) check("wb_ready_idle", wb_ready, 0);
            if (rel >= 1 && done_cnt == 0) check("busy", busy, 1);
            if (vel_out_valid) begin
                beat_idx = 8'(exp_next);
                check("beat_addr", vel_out_addr, beat_idx);
                check("beat_data", vel_out, shadow[beat_idx]);
                if (cur_mode == 1) check("beat_cycle", rel, 3 + exp_next);
                exp_next++;
                beats++;
            end
            if (cur_mode == 1 && rel == 1) begin
                check("fetch_rden", mem_rden, 1);
                check("fetch_addr", mem_address, 0);
            end
            if (cur_mode == 2 && rel == 3) begin
                check("prio_wren", mem_wren, 1);
                check("prio_rden", mem_rden, 0);
            end
            if (cur_mode == 2 && rel == 4) begin
                check("stall_rden", mem_rden, 1);
                check("stall_addr", mem_address, 1);
            end
            if (done) done_cnt++;
            if (mon_legal) begin
                shadow[wb_addr] = wb_data;
                wr_cnt++;
            end else if (mon_acc) begin
                exp_err = 1'b1;
            end
            if (start && !busy) exp_err = 1'b0;
        end
    end

    // Mode 0: random writes; 1: reads first then writes N..1; 2: write at first RUN cycle
    task automatic drive_wb(input int mode);
        wb_valid = 1'b0;
        wb_data  = {$urandom, $urandom, $urandom};
        if (wr_cnt >= exp_n) return;
        if (mode == 2 && rel == 3) begin
            wb_valid = 1'b1;
            wb_addr  = AW'(2);
        end else if (mode == 0 && rel == 3) begin
            wb_valid = 1'b1;
            wb_addr  = '0;
        end else if (beats >= exp_n) begin
            wb_valid = 1'b1;
            wb_addr  = (mode == 0) ? AW'($urandom_range(exp_n, 1)) : AW'(exp_n - wr_cnt);
        end else if (mode == 0 && $urandom_range(9, 0) < 3) begin
            wb_valid = 1'b1;
            if ($urandom_range(9, 0) == 0 && exp_n < 255)
                wb_addr = AW'($urandom_range(255, exp_n + 1));
            else
                wb_addr = AW'($urandom_range(exp_n, 1));
        end
    endtask

    // Mode 3: assert reset in cycle 5 (after two RUN reads).
    task automatic run_pass(input int mode, input int nraw);
        int limit;
        logic [7:0] n8;
        n8 = 8'(nraw);
        ram_img[0] = {$urandom, $urandom, 24'($urandom), n8};
        for (int i = 1; i < 256; i++) ram_img[i] = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 256; i++) shadow[i] = ram_img[i];
        exp_n    = (nraw > PN - 1) ? PN - 1 : nraw;
        beats    = 0;
        exp_next = 1;
        wr_cnt   = 0;
        done_cnt = 0;
        cur_mode = mode;
        rel      = 0;
        @(posedge clk); #1 ram_load = 1'b1;
        @(posedge clk); #1 ram_load = 1'b0;
        start  = 1'b1;
        mon_on = 1'b1;
        limit  = 4 * exp_n + 40;
        while (done_cnt == 0 && rel < limit) begin
            @(posedge clk); #1;
            rel++;
            start = 1'b0;
            if (mode == 3 && rel == 5) begin
                rst      = 1'b1;
                mon_on   = 1'b0;
                wb_valid = 1'b0;
                @(negedge clk);
                check("rst_beats_before", beats, 1);
                check("rst_busy", busy, 0);
                check("rst_valid", vel_out_valid, 0);
                check("rst_rden", mem_rden, 0);
                check("rst_wren", mem_wren, 0);
                check("rst_addr", mem_address, 0);
                check("rst_data", mem_data, 0);
                check("rst_wb_ready", wb_ready, 0);
                check("rst_done", done, 0);
                check("rst_pnum", particle_num, 0);
                check("rst_err", err, 0);
                @(posedge clk); #1 rst = 1'b0;
                exp_err = 1'b0;
                return;
            end
            drive_wb(mode);
        end
        wb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("beats", beats, exp_n);
        check("writes", wr_cnt, exp_n);
        check("pnum", particle_num, exp_n);
        check("busy_end", busy, 0);
        mon_on = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", vel_out_valid, 0);
        check("reset_rden", mem_rden, 0);
        check("reset_wren", mem_wren, 0);
        check("reset_addr", mem_address, 0);
        check("reset_wb_ready", wb_ready, 0);
        check("reset_err", err, 0);
        check("reset_pnum", particle_num, 0);
        rst = 1'b0;

        run_pass(1, 4);     // basic pass
        run_pass(2, 3);     // write priority
        run_pass(0, 0);     // empty cell
        run_pass(0, 255);   // clamp plus illegal write to address 0
        run_pass(1, 5);     // err must clear on this start
        run_pass(3, 6);     // reset mid-pass
        run_pass(1, 4);     // fresh pass after reset
        for (int k = 0; k < 5; k++) run_pass(0, int'($urandom_range(60, 1)));
        run_pass(0, PN - 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
